// File: rtl/jt51_mmr_dec.sv
//------------------------------------------------------------------------------
// Module   : jt51_mmr_dec
// Function : YM2151-style CPU register write decoder. Latches the register
//            address, applies data writes on the P1 clock enable, drives the
//            held per-slot update strobes with op/ch/data for one full slot
//            round, and holds the global (noise/timer/LFO/CT) registers.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module jt51_mmr_dec #(
  parameter int BUSY_CNT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       busy,
  output logic [7:0] dout,
  output logic [1:0] op,
  output logic [2:0] ch,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks,
  output logic       up_amsen,
  output logic       up_dt2,
  output logic       up_d1l,
  output logic       up_keyon,
  output logic       ne,
  output logic [4:0] nfrq,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       csm,
  output logic       load_A,
  output logic       load_B,
  output logic       en_irq_A,
  output logic       en_irq_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [7:0] lfo_freq,
  output logic [6:0] amd,
  output logic [6:0] pmd,
  output logic       ct1,
  output logic       ct2,
  output logic [1:0] lfo_w
);

  localparam int              CW       = (BUSY_CNT > 2) ? $clog2(BUSY_CNT) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(BUSY_CNT - 1);

  // Strobe vector bit positions
  localparam int S_KEYON = 0;
  localparam int S_D1L   = 1;
  localparam int S_DT2   = 2;
  localparam int S_AMSEN = 3;
  localparam int S_KS    = 4;
  localparam int S_TL    = 5;
  localparam int S_DT1   = 6;
  localparam int S_PMS   = 7;
  localparam int S_KF    = 8;
  localparam int S_KC    = 9;
  localparam int S_RL    = 10;

  logic          r_act_d;
  logic [7:0]    r_addr;
  logic          r_pend;
  logic [7:0]    r_pdata;
  logic [CW-1:0] r_cnt;
  logic [10:0]   r_strb;

  logic          w_act;
  logic          w_wr;
  logic          w_clear;
  logic          w_data_ok;
  logic          w_apply;
  logic [10:0]   w_strb;
  logic [1:0]    w_op;
  logic [2:0]    w_ch;

  // Bus activity is edge-qualified so a long low pulse is a single write.
  assign w_act     = ~cs_n & ~wr_n;
  assign w_wr      = w_act & ~r_act_d;
  // The cen on which the busy period ends; a write on this clk is not blocked.
  assign w_clear   = cen & busy & (r_cnt == '0);
  assign w_data_ok = w_wr & a0 & ~r_pend & (~busy | w_clear);
  assign w_apply   = cen & r_pend & ~busy;

  assign up_keyon = r_strb[S_KEYON];
  assign up_d1l   = r_strb[S_D1L];
  assign up_dt2   = r_strb[S_DT2];
  assign up_amsen = r_strb[S_AMSEN];
  assign up_ks    = r_strb[S_KS];
  assign up_tl    = r_strb[S_TL];
  assign up_dt1   = r_strb[S_DT1];
  assign up_pms   = r_strb[S_PMS];
  assign up_kf    = r_strb[S_KF];
  assign up_kc    = r_strb[S_KC];
  assign up_rl    = r_strb[S_RL];

  // Decode the latched address into a one-hot strobe and its op/ch target.
  always_comb begin
    w_strb = '0;
    w_op   = r_addr[4:3];
    w_ch   = r_addr[2:0];
    if (r_addr == 8'h08) begin
      w_strb[S_KEYON] = 1'b1;
      w_op            = 2'd0;
      w_ch            = r_pdata[2:0];
    end else if (r_addr[7:5] == 3'b001) begin
      w_op = 2'd0;
      case (r_addr[4:3])
        2'd0:    w_strb[S_RL]  = 1'b1;
        2'd1:    w_strb[S_KC]  = 1'b1;
        2'd2:    w_strb[S_KF]  = 1'b1;
        default: w_strb[S_PMS] = 1'b1;
      endcase
    end else if (r_addr[7:6] != 2'b00) begin
      case (r_addr[7:5])
        3'd2:    w_strb[S_DT1]   = 1'b1;
        3'd3:    w_strb[S_TL]    = 1'b1;
        3'd4:    w_strb[S_KS]    = 1'b1;
        3'd5:    w_strb[S_AMSEN] = 1'b1;
        3'd6:    w_strb[S_DT2]   = 1'b1;
        default: w_strb[S_D1L]   = 1'b1;
      endcase
    end
  end

  // CPU bus capture: address latch and single-entry pending data write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_d <= 1'b0;
      r_addr  <= 8'h00;
      r_pend  <= 1'b0;
      r_pdata <= 8'h00;
    end else begin
      r_act_d <= w_act;
      if (w_wr && !a0) begin
        r_addr <= din;
      end
      if (w_apply) begin
        r_pend <= 1'b0;
      end else if (w_data_ok) begin
        r_pend  <= 1'b1;
        r_pdata <= din;
      end
    end
  end

  // Pipeline-facing outputs: apply a pending write and hold it for one slot round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      r_cnt  <= '0;
      r_strb <= '0;
      dout   <= 8'h00;
      op     <= 2'd0;
      ch     <= 3'd0;
    end else if (cen) begin
      if (busy) begin
        if (r_cnt == '0) begin
          busy   <= 1'b0;
          r_strb <= '0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end else if (r_pend) begin
        busy   <= 1'b1;
        r_cnt  <= CNT_LOAD;
        r_strb <= w_strb;
        if (|w_strb) begin
          dout <= r_pdata;
          op   <= w_op;
          ch   <= w_ch;
        end
      end
    end
  end

  // Global registers, updated on the applying cen; flag clears last one cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ne         <= 1'b0;
      nfrq       <= 5'd0;
      value_A    <= 10'd0;
      value_B    <= 8'd0;
      csm        <= 1'b0;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      en_irq_A   <= 1'b0;
      en_irq_B   <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      lfo_freq   <= 8'd0;
      amd        <= 7'd0;
      pmd        <= 7'd0;
      ct1        <= 1'b0;
      ct2        <= 1'b0;
      lfo_w      <= 2'd0;
    end else if (cen) begin
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (w_apply) begin
        case (r_addr)
          8'h0F: begin
            ne   <= r_pdata[7];
            nfrq <= r_pdata[4:0];
          end
          8'h10: value_A[9:2] <= r_pdata;
          8'h11: value_A[1:0] <= r_pdata[1:0];
          8'h12: value_B      <= r_pdata;
          8'h14: begin
            csm        <= r_pdata[7];
            load_A     <= r_pdata[0];
            load_B     <= r_pdata[1];
            en_irq_A   <= r_pdata[2];
            en_irq_B   <= r_pdata[3];
            clr_flag_A <= r_pdata[4];
            clr_flag_B <= r_pdata[5];
          end
          8'h18: lfo_freq <= r_pdata;
          8'h19: begin
            if (r_pdata[7]) pmd <= r_pdata[6:0];
            else            amd <= r_pdata[6:0];
          end
          8'h1B: begin
            ct1   <= r_pdata[6];
            ct2   <= r_pdata[7];
            lfo_w <= r_pdata[1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jt51_mmr_dec.sv
//------------------------------------------------------------------------------
// Module   : tb_jt51_mmr_dec
// Function : Randomized self-checking bench for jt51_mmr_dec against a
//            transaction-level reference model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jt51_mmr_dec;

  localparam int BUSY = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'h00;

  logic       busy;
  logic [7:0] dout;
  logic [1:0] op;
  logic [2:0] ch;
  logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen;
  logic       up_dt2, up_d1l, up_keyon;
  logic       ne;
  logic [4:0] nfrq;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       csm, load_A, load_B, en_irq_A, en_irq_B, clr_flag_A, clr_flag_B;
  logic [7:0] lfo_freq;
  logic [6:0] amd, pmd;
  logic       ct1, ct2;
  logic [1:0] lfo_w;

  int n_tests = 0;
  int n_fail  = 0;
  int cen_pct = 100;

  jt51_mmr_dec #(.BUSY_CNT(BUSY)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .a0(a0),
    .din(din), .busy(busy), .dout(dout), .op(op), .ch(ch),
    .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms),
    .up_dt1(up_dt1), .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen),
    .up_dt2(up_dt2), .up_d1l(up_d1l), .up_keyon(up_keyon),
    .ne(ne), .nfrq(nfrq), .value_A(value_A), .value_B(value_B),
    .csm(csm), .load_A(load_A), .load_B(load_B), .en_irq_A(en_irq_A),
    .en_irq_B(en_irq_B), .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .lfo_freq(lfo_freq), .amd(amd), .pmd(pmd), .ct1(ct1), .ct2(ct2),
    .lfo_w(lfo_w)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  bit         m_prev;
  logic [7:0] m_addr;
  bit         m_pend;
  logic [7:0] m_pdata;
  int         m_left;      // cen ticks of busy still to elapse
  int         m_sel;       // active strobe index, -1 when none
  logic [7:0] m_dout;
  logic [1:0] m_op;
  logic [2:0] m_ch;
  logic [7:0] m_reg [0:255];  // last value written to each global address
  logic [9:0] m_valA;
  logic [6:0] m_amd, m_pmd;
  bit         m_clrA, m_clrB;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe index: 0 keyon, 1 d1l .. 6 dt1 (0x40 step 0x20), 7 pms .. 10 rl (0x20 step 8)
  function automatic int strobe_of(input logic [7:0] a);
    int ai;
    ai = int'(a);
    if (ai == 8) return 0;
    if (ai >= 32 && ai < 64) return 10 - (ai - 32) / 8;
    if (ai >= 64) return 6 - (ai - 64) / 32;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_addr = 0; m_pend = 0; m_pdata = 0; m_left = 0; m_sel = -1;
    m_dout = 0; m_op = 0; m_ch = 0; m_valA = 0; m_amd = 0; m_pmd = 0;
    m_clrA = 0; m_clrB = 0;
    for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;
  endtask

  task automatic model_apply(input logic [7:0] a, input logic [7:0] d);
    int s;
    s = strobe_of(a);
    m_sel  = s;
    m_left = BUSY;
    if (s >= 0) begin
      m_dout = d;
      if (s == 0) begin
        m_op = 0; m_ch = d % 8;
      end else if (s >= 7) begin
        m_op = 0; m_ch = a % 8;
      end else begin
        m_op = (a / 8) % 4; m_ch = a % 8;
      end
    end else begin
      m_reg[a] = d;
      if (a == 8'h10) m_valA = {d, m_valA[1:0]};
      if (a == 8'h11) m_valA = {m_valA[9:2], d[1:0]};
      if (a == 8'h19) begin
        if (d >= 8'h80) m_pmd = 7'(d - 8'h80);
        else            m_amd = 7'(d);
      end
      if (a == 8'h14) begin
        m_clrA = d[4]; m_clrB = d[5];
      end
    end
  endtask

  // One clk edge of the model, using the inputs as they stood at the edge.
  task automatic model_step();
    bit act, wr, old_pend;
    int old_left;
    logic [7:0] old_addr;
    act = !cs_n && !wr_n;
    wr  = act && !m_prev;
    m_prev   = act;
    old_pend = m_pend;
    old_left = m_left;
    old_addr = m_addr;
    if (cen) begin
      m_clrA = 0; m_clrB = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_sel = -1;
      end else if (m_pend) begin
        model_apply(old_addr, m_pdata);
        m_pend = 0;
      end
    end
    if (wr && !a0) m_addr = din;
    if (wr && a0 && !old_pend && (old_left == 0 || (cen && old_left == 1))) begin
      m_pend  = 1;
      m_pdata = din;
    end
  endtask

  task automatic check_all();
    logic [10:0] strb, exp_strb;
    logic [7:0]  r14, r1b, r0f;
    strb = {up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen,
            up_dt2, up_d1l, up_keyon};
    exp_strb = '0;
    if (m_sel >= 0) exp_strb[m_sel] = 1'b1;
    r14 = m_reg[8'h14]; r1b = m_reg[8'h1B]; r0f = m_reg[8'h0F];
    check("busy",    64'(busy), 64'(m_left > 0));
    check("strobes", 64'(strb), 64'(exp_strb));
    check("dout",    64'(dout), 64'(m_dout));
    check("op_ch",   64'({op, ch}), 64'({m_op, m_ch}));
    check("noise",   64'({ne, nfrq}), 64'({r0f[7], r0f[4:0]}));
    check("timers",  64'({value_A, value_B}), 64'({m_valA, m_reg[8'h12]}));
    check("ctrl14",  64'({csm, en_irq_B, en_irq_A, load_B, load_A}),
                     64'({r14[7], r14[3], r14[2], r14[1], r14[0]}));
    check("clrflag", 64'({clr_flag_B, clr_flag_A}), 64'({m_clrB, m_clrA}));
    check("lfo",     64'({lfo_freq, amd, pmd}), 64'({m_reg[8'h18], m_amd, m_pmd}));
    check("ct_w",    64'({ct2, ct1, lfo_w}), 64'({r1b[7], r1b[6], r1b[1:0]}));
  endtask

  // Advance one clock: model the edge, check at the falling edge, pick next cen.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    if (rst_n) check_all();
    cen = ($urandom_range(99) < cen_pct);
  endtask

  task automatic bus_wr(input logic is_data, input logic [7:0] d, input int hold);
    cs_n = 1'b0; wr_n = 1'b0; a0 = is_data; din = d;
    repeat (hold) tick();
    cs_n = 1'b1; wr_n = 1'b1; din = 8'($urandom);
    tick();
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    bus_wr(1'b0, a, 1);
    bus_wr(1'b1, d, 1);
  endtask

  logic [7:0] addr_tab [0:15];

  initial begin
    addr_tab = '{8'h08, 8'h20, 8'h2D, 8'h33, 8'h3F, 8'h5A, 8'h7F, 8'h80,
                 8'hA5, 8'hC3, 8'hFF, 8'h0F, 8'h10, 8'h14, 8'h19, 8'h1B};
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    cen = 1'b1;
    repeat (2) tick();

    // Slot writes, keyon, dropped write while busy, AMD/PMD, timer control
    reg_wr(8'h5A, 8'h37);  repeat (40) tick();
    reg_wr(8'h08, 8'h7D);  repeat (40) tick();
    reg_wr(8'h28, 8'h4A);  repeat (4) tick();
    bus_wr(1'b1, 8'hFF, 1); repeat (40) tick();
    reg_wr(8'h19, 8'h85);  repeat (40) tick();
    bus_wr(1'b1, 8'h13, 1); repeat (40) tick();
    reg_wr(8'h14, 8'h35);  repeat (40) tick();

    // Second data write landing around the busy-clearing cen
    for (int off = 28; off < 35; off++) begin
      reg_wr(8'h60, 8'(off));
      repeat (off) tick();
      bus_wr(1'b1, 8'(off + 100), 1);
      repeat (36) tick();
    end

    // Asynchronous reset in the middle of a busy period
    reg_wr(8'hC7, 8'hA9);
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strb", 64'({up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks,
                           up_amsen, up_dt2, up_d1l, up_keyon}), 64'd0);
    check("rst_dout", 64'({dout, op, ch}), 64'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Randomized traffic with varying cen density and pulse lengths
    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      if (n % 25 == 0) cen_pct = $urandom_range(100, 20);
      a = ($urandom_range(3) == 0) ? 8'($urandom) : addr_tab[$urandom_range(15)];
      if ($urandom_range(7) != 0) bus_wr(1'b0, a, $urandom_range(3, 1));
      bus_wr(1'b1, 8'($urandom), $urandom_range(3, 1));
      repeat ($urandom_range(45)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
